// File: rtl/bus_cycle_tracer_pkg.sv
// Shared types for the 6502 bus cycle tracer: trace entry layout and host byte selects.
package m6502_trace_pkg;

  localparam int SEQ_W = 5;

  typedef enum logic [1:0] {
    FLAGS   = 2'd0,
    DATA    = 2'd1,
    ADDR_LO = 2'd2,
    ADDR_HI = 2'd3
  } byte_sel_e;

  typedef struct packed {
    logic [15:0]      addr;
    logic [7:0]       data;
    logic             rw;
    logic             sync;
    logic             ovf;
    logic [SEQ_W-1:0] seq;
  } trace_entry_t;

  function automatic logic [7:0] entry_byte(input trace_entry_t e, input byte_sel_e sel);
    logic [7:0] b;
    case (sel)
      FLAGS:   b = {e.rw, e.sync, e.ovf, e.seq};
      DATA:    b = e.data;
      ADDR_LO: b = e.addr[7:0];
      ADDR_HI: b = e.addr[15:8];
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/bus_cycle_tracer_fifo.sv
// Single-clock FIFO (module trace_fifo) with extra-MSB pointers; a push into a full
// FIFO is accepted only when a pop is accepted in the same clock.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic                   push_ok,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign count   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/bus_cycle_tracer.sv
// Captures 6502 bus cycles on phi2 falling edges into a trace FIFO read byte-wise by a host.
// Optional address trigger enabled by defining TRACE_TRIGGER_EN.
module bus_cycle_tracer
  import m6502_trace_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_phi2,
  input  logic [15:0]            i_bus_addr,
  input  logic                   i_bus_rw,
  input  logic [7:0]             i_cpu_wdata,
  input  logic [7:0]             i_bus_rdata,
  input  logic                   i_sync,
  input  logic                   i_enable,
  input  logic [1:0]             i_byte_sel,
  input  logic                   i_pop,
`ifdef TRACE_TRIGGER_EN
  input  logic [15:0]            i_trig_addr,
  input  logic                   i_trig_arm,
  output logic                   o_triggered,
`endif
  output logic [7:0]             o_trace_byte,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow
);

  localparam int unsigned NS = SYNC_STAGES;

  logic             phi2_prev;
  logic             strobe_raw;
  logic             strobe;
  logic [SEQ_W-1:0] seq;
  logic             push_pend;
  trace_entry_t     cap_q;
  trace_entry_t     entry_in;
  trace_entry_t     head;
  logic [2:0]       sync_q [NS];
  logic             pop_s;
  logic             pop_prev;
  logic             pop_pulse;
  byte_sel_e        sel_s;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push_ok;

  assign strobe_raw = phi2_prev & ~i_phi2 & i_enable;

`ifdef TRACE_TRIGGER_EN
  logic trig_hit;

  // While armed, only the matching cycle and everything after it is traced.
  assign trig_hit = strobe_raw & i_trig_arm & ~o_triggered & (i_bus_addr == i_trig_addr);
  assign strobe   = strobe_raw & (~i_trig_arm | o_triggered | trig_hit);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)       o_triggered <= 1'b0;
    else if (!i_trig_arm) o_triggered <= 1'b0;
    else if (trig_hit)    o_triggered <= 1'b1;
  end
`else
  assign strobe = strobe_raw;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      phi2_prev <= 1'b0;
      seq       <= '0;
      push_pend <= 1'b0;
      cap_q     <= '0;
    end else begin
      phi2_prev <= i_phi2;
      push_pend <= strobe;
      if (strobe) begin
        cap_q.addr <= i_bus_addr;
        cap_q.data <= i_bus_rw ? i_bus_rdata : i_cpu_wdata;
        cap_q.rw   <= i_bus_rw;
        cap_q.sync <= i_sync;
        cap_q.ovf  <= 1'b0;
        cap_q.seq  <= seq;
        seq        <= seq + 1'b1;
      end
    end
  end

  // The ovf flag reflects the sticky at store time, not at capture time.
  always_comb begin
    entry_in     = cap_q;
    entry_in.ovf = o_overflow;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                o_overflow <= 1'b0;
    else if (push_ok)              o_overflow <= 1'b0;
    else if (push_pend)            o_overflow <= 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int unsigned i = 0; i < NS; i++) sync_q[i] <= '0;
      pop_prev <= 1'b0;
    end else begin
      sync_q[0] <= {i_byte_sel, i_pop};
      for (int unsigned i = 1; i < NS; i++) sync_q[i] <= sync_q[i-1];
      pop_prev <= pop_s;
    end
  end

  assign pop_s     = sync_q[NS-1][0];
  assign sel_s     = byte_sel_e'(sync_q[NS-1][2:1]);
  assign pop_pulse = pop_s & ~pop_prev;

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(trace_entry_t))
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_reset_n),
    .push    (push_pend),
    .pop     (pop_pulse),
    .wdata   (entry_in),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .push_ok (push_ok),
    .count   (o_count)
  );

  assign o_empty = fifo_empty;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)      o_trace_byte <= '0;
    else if (fifo_empty) o_trace_byte <= '0;
    else                 o_trace_byte <= entry_byte(head, sel_s);
  end

endmodule

// File: doc/bus_cycle_tracer.md
Name: bus_cycle_tracer

Overview:
- Captures every 6502 bus cycle (address, data, R/W, SYNC) on the falling edge of phi2 and stores it in a trace FIFO.
- An external host reads the FIFO byte-wise over the same pin-selected data port that the external bus multiplexer drives.
- Sits beside the mcu, upstream of the bus multiplexer. Its byte output is one of the sources the multiplexer presents on the shared 8-bit data pins.
- Runs in the 50 MHz system clock domain.

Parameters:
- DEPTH, 16, number of trace entries; power of two, minimum 4.
- SYNC_STAGES, 2, synchronizer flops on the host-side pins (i_byte_sel, i_pop).

Ports:
- i_clk  in  1  system clock (50 MHz)
- i_reset_n  in  1  asynchronous active-low reset
- i_phi2  in  1  CPU phi2, generated in the i_clk domain
- i_bus_addr  in  16  CPU address bus
- i_bus_rw  in  1  1 = read, 0 = write
- i_cpu_wdata  in  8  data driven by the CPU (write cycles)
- i_bus_rdata  in  8  data returned to the CPU (read cycles)
- i_sync  in  1  CPU opcode-fetch indicator
- i_enable  in  1  capture enable (level)
- i_byte_sel  in  2  host byte select, asynchronous pins
- i_pop  in  1  host pop strobe, asynchronous pin, rising edge = pop
- o_trace_byte  out  8  selected byte of the FIFO head entry
- o_empty  out  1  FIFO empty
- o_count  out  $clog2(DEPTH)+1  number of stored entries
- o_overflow  out  1  sticky flag: at least one cycle was dropped since the last stored entry

Behaviour:
- Reset (async assert, sync release is handled upstream):
  - FIFO pointers 0, o_count 0, o_empty 1, o_overflow 0, o_trace_byte 0x00.
  - Synchronizers and phi2_prev cleared.
- Capture:
  - phi2_prev is registered every clock; capture strobe = phi2_prev & ~i_phi2 & i_enable.
  - i_phi2 is not synchronized; it is already in the i_clk domain.
- Entry format, 32 bits:
  - byte3 = addr[15:8]
  - byte2 = addr[7:0]
  - byte1 = data, equal to i_bus_rdata if rw=1, else i_cpu_wdata
  - byte0 = {rw, sync, ovf, seq[4:0]}
  - seq is a 5-bit per-capture counter that increments on every capture strobe, stored or dropped, and wraps from 31 to 0.
  - ovf = 1 if the overflow sticky was set when this entry was stored.
- Push: the entry is written one clock after the strobe, from inputs registered on the strobe clock.
- Full:
  - A push when full is dropped and o_overflow is set.
  - The next successful push carries ovf=1 and clears o_overflow in the same clock.
- Pop:
  - i_pop passes through SYNC_STAGES flops; a rising edge of the synchronized signal produces a single-cycle pop.
  - Pop when empty is ignored and pointers are unchanged.
- Simultaneous push and pop:
  - Not full: both take effect and count is unchanged.
  - Full: pop and push both accepted, count stays DEPTH, no overflow.
- Readout:
  - o_trace_byte is registered: selected byte of the head entry, using the synchronized i_byte_sel.
  - It is valid 1 clock after a head change or select change.
  - 0x00 when empty.
- Pointers are $clog2(DEPTH)+1 bits wide with natural wrap; full = MSBs differ and lower bits equal.
- i_enable low: no captures and the seq counter holds. A pending registered push still completes.

Optional Feature:
- TRACE_TRIGGER_EN
  - When defined, adds ports i_trig_addr[15:0] and i_trig_arm (level), plus output o_triggered.
  - While armed and not yet triggered, captures are discarded.
  - The first capture strobe with addr == i_trig_addr sets o_triggered and is stored as the first entry.
  - Deasserting i_trig_arm clears o_triggered.
- When undefined: capture is governed by i_enable alone, with no extra ports or logic.

Decomposition:
- Package m6502_trace_pkg holds:
  - trace_entry_t, a packed struct of addr, data, rw, sync, ovf, seq;
  - enum byte_sel_e: FLAGS=0, DATA=1, ADDR_LO=2, ADDR_HI=3;
  - localparam SEQ_W=5.
- One sub-module, trace_fifo: synchronous single-clock FIFO with push/pop/full/empty/count, parameterized on DEPTH and width.

Test Plan:
- Reset mid-capture with 3 entries stored → o_count=0, o_empty=1, o_trace_byte=0x00, o_overflow=0 immediately, before any clock edge.
- Read cycle addr 0xFFFC, rdata 0x34, sync=1, first capture → bytes read as sel3=0xFF, sel2=0xFC, sel1=0x34, sel0=0xC0 (rw=1, sync=1, seq=0).
- Write cycle addr 0x0200, wdata 0x5A, rdata 0xEE → sel1 reads 0x5A and sel0 bit7=0.
- 18 captures with DEPTH=16 and no pops → o_count=16 and o_overflow=1. Pop one, then capture one more → new entry has ovf=1, seq=18, and o_overflow clears.
- Pop edge and capture strobe in the same clock with FIFO full → o_count stays 16, o_overflow stays 0, head advances one entry.
- Pop on empty FIFO; then i_pop held high for 100 clocks → pointers unchanged on the empty pop; the held-high pulse yields exactly one pop once an entry exists.
